// File: rtl/tc_io_pkg.sv
// rtl/tc_io_pkg.sv - shared types and constants for the tiny computer serial I/O ports
package tc_io_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_t;

  localparam int TC_OVERSAMPLE = 16;
  localparam int TC_MID_SAMPLE = 7;
  localparam int TC_DATA_BITS  = 8;
  localparam int TC_IN_DATA_W  = 32;

endpackage

// File: rtl/tc_sync_fifo.sv
// rtl/tc_sync_fifo.sv - circular-buffer FIFO with wrap-bit pointers, shared by the serial ports
module tc_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count   = wr_ptr - rd_ptr;
  assign do_pop  = pop && !empty;
  // A pop frees the head slot at the same edge, so a push while full still fits.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/tc_uart_rx.sv
// rtl/tc_uart_rx.sv - 16x oversampled serial receiver feeding the core's input path
// Define TC_UART_RX_PARITY_EN for 8E1 framing with a parity check; default is 8N1.
module tc_uart_rx
  import tc_io_pkg::*;
#(
  parameter int BAUD_DIV = 54,
  parameter int DEPTH    = 16
) (
  input  logic                      Ph0,
  input  logic                      ResetN,
  input  logic                      Rxd,
  input  logic                      InStrobe,
  input  logic                      ClrErr,
  output logic [TC_IN_DATA_W-1:0]   InData,
  output logic                      InRdy,
  output logic [$clog2(DEPTH):0]    Count,
  output logic                      Overrun,
  output logic                      FrameErr,
  output logic                      ParityErr
);

  logic                    rx_meta;
  logic                    rxs;
  logic [11:0]             div_cnt;
  logic                    tick;
  rx_state_t               state, state_n;
  logic [3:0]              sc, sc_n;
  logic [2:0]              bitn, bitn_n;
  logic [TC_DATA_BITS-1:0] shreg, shreg_n;
  logic                    push;
  logic                    frame_set;
  logic                    ov_set;
  logic                    par_bad;
  logic [TC_DATA_BITS-1:0] head;
  logic                    full;
  logic                    empty;

  always_ff @(posedge Ph0 or negedge ResetN) begin
    if (!ResetN) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= Rxd;
      rxs     <= rx_meta;
    end
  end

  // Held at zero while idle so the first tick lands BAUD_DIV cycles after the start edge.
  assign tick = (div_cnt == 12'(BAUD_DIV - 1));

  always_ff @(posedge Ph0 or negedge ResetN) begin
    if (!ResetN)                      div_cnt <= '0;
    else if (state == ST_IDLE || tick) div_cnt <= '0;
    else                              div_cnt <= div_cnt + 12'd1;
  end

  always_ff @(posedge Ph0 or negedge ResetN) begin
    if (!ResetN) begin
      state <= ST_IDLE;
      sc    <= '0;
      bitn  <= '0;
      shreg <= '0;
    end else begin
      state <= state_n;
      sc    <= sc_n;
      bitn  <= bitn_n;
      shreg <= shreg_n;
    end
  end

`ifdef TC_UART_RX_PARITY_EN
  logic par_bad_n;
  logic par_set;
`endif

  always_comb begin
    state_n   = state;
    sc_n      = sc;
    bitn_n    = bitn;
    shreg_n   = shreg;
    push      = 1'b0;
    frame_set = 1'b0;
`ifdef TC_UART_RX_PARITY_EN
    par_bad_n = par_bad;
    par_set   = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        if (!rxs) begin
          state_n = ST_START;
          sc_n    = '0;
        end
      end
      ST_START: begin
        if (tick) begin
          if (sc == 4'(TC_MID_SAMPLE)) begin
            sc_n    = '0;
            bitn_n  = '0;
            state_n = rxs ? ST_IDLE : ST_DATA;
          end else begin
            sc_n = sc + 4'd1;
          end
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (sc == 4'(TC_OVERSAMPLE - 1)) begin
            shreg_n = {rxs, shreg[TC_DATA_BITS-1:1]};
            sc_n    = '0;
            bitn_n  = bitn + 3'd1;
            if (bitn == 3'(TC_DATA_BITS - 1)) begin
`ifdef TC_UART_RX_PARITY_EN
              state_n = ST_PARITY;
`else
              state_n = ST_STOP;
`endif
            end
          end else begin
            sc_n = sc + 4'd1;
          end
        end
      end
`ifdef TC_UART_RX_PARITY_EN
      ST_PARITY: begin
        if (tick) begin
          if (sc == 4'(TC_OVERSAMPLE - 1)) begin
            par_bad_n = (^shreg) ^ rxs;
            par_set   = par_bad_n;
            sc_n      = '0;
            state_n   = ST_STOP;
          end else begin
            sc_n = sc + 4'd1;
          end
        end
      end
`endif
      ST_STOP: begin
        if (tick) begin
          if (sc == 4'(TC_OVERSAMPLE - 1)) begin
            push      = rxs && !par_bad;
            frame_set = !rxs;
            sc_n      = '0;
            state_n   = ST_IDLE;
          end else begin
            sc_n = sc + 4'd1;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

`ifdef TC_UART_RX_PARITY_EN
  always_ff @(posedge Ph0 or negedge ResetN) begin
    if (!ResetN) begin
      par_bad   <= 1'b0;
      ParityErr <= 1'b0;
    end else begin
      par_bad   <= par_bad_n;
      ParityErr <= ClrErr ? 1'b0 : (ParityErr | par_set);
    end
  end
`else
  assign par_bad   = 1'b0;
  assign ParityErr = 1'b0;
`endif

  // A full FIFO only drops the byte when no pop frees a slot at the same edge.
  assign ov_set = push && full && !InStrobe;

  always_ff @(posedge Ph0 or negedge ResetN) begin
    if (!ResetN) begin
      Overrun  <= 1'b0;
      FrameErr <= 1'b0;
    end else begin
      Overrun  <= ClrErr ? 1'b0 : (Overrun | ov_set);
      FrameErr <= ClrErr ? 1'b0 : (FrameErr | frame_set);
    end
  end

  tc_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (TC_DATA_BITS)
  ) u_fifo (
    .clk   (Ph0),
    .rst_n (ResetN),
    .push  (push),
    .wdata (shreg),
    .pop   (InStrobe),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (Count)
  );

  assign InRdy  = !empty;
  assign InData = empty ? '0 : {{(TC_IN_DATA_W - TC_DATA_BITS){1'b0}}, head};

endmodule

// File: tb/tb_tc_uart_rx.sv
// tb/tb_tc_uart_rx.sv - directed and randomized frames against a byte-queue model of tc_uart_rx
module tb_tc_uart_rx;

  localparam int BAUD_DIV = 4;
  localparam int DEPTH    = 16;
  localparam int BIT_CYC  = 16 * BAUD_DIV;
`ifdef TC_UART_RX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  // Edge (counted from the one before the start bit is driven) that samples mid-stop:
  // 2 sync flops + 1 IDLE->START + 8 ticks to mid-start + 16 ticks per later bit.
  localparam int PUSH_EDGE = 3 + 8 * BAUD_DIV + BIT_CYC * (NBITS - 1);

  logic        Ph0 = 1'b0;
  logic        ResetN;
  logic        Rxd;
  logic        InStrobe;
  logic        ClrErr;
  logic [31:0] InData;
  logic        InRdy;
  logic [4:0]  Count;
  logic        Overrun;
  logic        FrameErr;
  logic        ParityErr;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] q[$];
  bit m_ov, m_fe, m_pe;

  tc_uart_rx #(.BAUD_DIV(BAUD_DIV), .DEPTH(DEPTH)) dut (
    .Ph0(Ph0), .ResetN(ResetN), .Rxd(Rxd), .InStrobe(InStrobe), .ClrErr(ClrErr),
    .InData(InData), .InRdy(InRdy), .Count(Count), .Overrun(Overrun),
    .FrameErr(FrameErr), .ParityErr(ParityErr)
  );

  always #5 Ph0 = ~Ph0;

  task automatic step(input int n);
    repeat (n) @(posedge Ph0);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_data();
    return (q.size() != 0) ? {24'b0, q[0]} : 32'b0;
  endfunction

  task automatic check_all(input string tag);
    check({tag, ".rdy"},  {31'b0, InRdy},     {31'b0, q.size() != 0});
    check({tag, ".cnt"},  {27'b0, Count},     32'(q.size()));
    check({tag, ".data"}, InData,             exp_data());
    check({tag, ".ov"},   {31'b0, Overrun},   {31'b0, m_ov});
    check({tag, ".fe"},   {31'b0, FrameErr},  {31'b0, m_fe});
    check({tag, ".pe"},   {31'b0, ParityErr}, {31'b0, m_pe});
  endtask

  task automatic do_pop(input string tag);
    check({tag, ".head"}, InData, exp_data());
    InStrobe = 1'b1;
    step(1);
    InStrobe = 1'b0;
    if (q.size() != 0) void'(q.pop_front());
  endtask

  task automatic do_clr();
    ClrErr = 1'b1;
    step(1);
    ClrErr = 1'b0;
    m_ov = 0; m_fe = 0; m_pe = 0;
  endtask

  // pop_edge / clr_edge: frame-relative edge at which InStrobe / ClrErr is sampled high (-1: never).
  task automatic send_frame(input logic [7:0] d, input bit stop_ok, input bit par_ok,
                            input int pop_edge, input int clr_edge, input int idle);
    logic bits [NBITS];
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i + 1] = d[i];
`ifdef TC_UART_RX_PARITY_EN
    bits[9] = (^d) ^ !par_ok;
`endif
    bits[NBITS - 1] = stop_ok;
    for (int c = 0; c < NBITS * BIT_CYC; c++) begin
      Rxd      = bits[c / BIT_CYC];
      InStrobe = (c + 1 == pop_edge);
      ClrErr   = (c + 1 == clr_edge);
      if (InStrobe) begin
        check("frame.pop_head", InData, exp_data());
        if (q.size() != 0) void'(q.pop_front());
      end
      if (ClrErr) begin
        m_ov = 0; m_fe = 0; m_pe = 0;
      end
      step(1);
    end
    Rxd = 1'b1; InStrobe = 1'b0; ClrErr = 1'b0;
    if (clr_edge != PUSH_EDGE) begin
      if (!stop_ok) m_fe = 1;
      if (!par_ok)  m_pe = 1;
    end
    if (stop_ok && par_ok) begin
      if (q.size() < DEPTH) q.push_back(d);
      else if (clr_edge != PUSH_EDGE) m_ov = 1;
    end
    step(idle);
  endtask

  initial begin
    logic [7:0] d;
    ResetN = 1'b0; Rxd = 1'b1; InStrobe = 1'b0; ClrErr = 1'b0;
    step(3);
    check_all("reset");
    ResetN = 1'b1;
    step(4);

    // Single byte, then one pop
    send_frame(8'hA5, 1, 1, -1, -1, 0);
    check_all("a5");
    do_pop("a5");
    check_all("a5.popped");

    // Overflow by one, then drain in order
    for (int i = 0; i <= DEPTH; i++) send_frame(8'(i), 1, 1, -1, -1, 0);
    check_all("ovf");
    for (int i = 0; i < DEPTH; i++) do_pop("drain");
    check_all("drained");
    do_clr();
    check_all("ovf.clr");

    // Bad stop bit, then normal frame
    send_frame(8'h3C, 0, 1, -1, -1, 2 * BIT_CYC);
    check_all("frame_err");
    send_frame(8'h3D, 1, 1, -1, -1, 0);
    check_all("after_fe");
    do_pop("3d");
    do_clr();

    // ClrErr on the same edge as a framing error wins
    send_frame(8'h77, 0, 1, -1, PUSH_EDGE, 2 * BIT_CYC);
    check_all("clr_prio");

    // Short low glitch on idle line
    Rxd = 1'b0; step(3); Rxd = 1'b1;
    step(3 * BIT_CYC);
    check_all("glitch");

    // Full FIFO with a pop on the exact push edge
    for (int i = 0; i < DEPTH; i++) send_frame(8'($urandom), 1, 1, -1, -1, 0);
    check_all("full");
    send_frame(8'hE7, 1, 1, PUSH_EDGE, -1, 0);
    check_all("full.pushpop");
    for (int i = 0; i < DEPTH; i++) do_pop("full.drain");
    check_all("full.empty");

    // Reset mid-DATA with two bytes queued
    send_frame(8'h11, 1, 1, -1, -1, 0);
    send_frame(8'h22, 1, 1, -1, -1, 0);
    Rxd = 1'b0; step(BIT_CYC);
    Rxd = 1'b1; step(BIT_CYC + BIT_CYC / 2);
    ResetN = 1'b0;
    #1;
    q.delete(); m_ov = 0; m_fe = 0; m_pe = 0;
    check_all("reset_mid");
    step(2);
    ResetN = 1'b1;
    step(2 * BIT_CYC);
    send_frame(8'h5A, 1, 1, -1, -1, 0);
    check_all("after_reset");
    do_pop("5a");

`ifdef TC_UART_RX_PARITY_EN
    send_frame(8'h01, 1, 0, -1, -1, 0);
    check_all("parity_err");
    send_frame(8'h02, 0, 0, -1, -1, 2 * BIT_CYC);
    check_all("parity_and_frame");
    do_clr();
`endif

    // Randomized frames with occasional bad stop bits, pops and clears
    for (int i = 0; i < 16; i++) begin
      bit ok;
      d  = 8'($urandom);
      ok = ($urandom_range(0, 5) != 0);
      send_frame(d, ok, 1, -1, -1, ok ? 0 : 2 * BIT_CYC);
      check_all("rand");
      for (int p = $urandom_range(0, 2); p > 0; p--) do_pop("rand");
      if ($urandom_range(0, 3) == 0) do_clr();
      check_all("rand.post");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
